// File: rtl/five_stage_pkg.sv
// Shared state encoding, opcode constants and opcode legality helper for the
// five-stage control sequencer.
package five_stage_pkg;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'b000,
        ST_DECODE    = 3'b001,
        ST_EXECUTE   = 3'b010,
        ST_MEM       = 3'b011,
        ST_WRITE_OUT = 3'b100,
        ST_HALT      = 3'b101
    } state_t;

    localparam logic [5:0] OP_ALU  = 6'h00;
    localparam logic [5:0] OP_ALUI = 6'h01;
    localparam logic [5:0] OP_LD   = 6'h02;
    localparam logic [5:0] OP_ST   = 6'h03;
    localparam logic [5:0] OP_BR   = 6'h04;
    localparam logic [5:0] OP_JMP  = 6'h05;
    localparam logic [5:0] OP_HALT = 6'h3F;

    function automatic logic is_legal_op(input logic [5:0] op);
        case (op)
            OP_ALU, OP_ALUI, OP_LD, OP_ST, OP_BR, OP_JMP, OP_HALT: is_legal_op = 1'b1;
            default:                                              is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/five_stage_wait_timer.sv
// Memory wait-state counter. expired flags the last permitted wait cycle, so
// the sequencer can leave for HALT on that cycle unless an ack arrives.
module five_stage_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    logic [CW-1:0] cnt_r;

    // Wait counter: cleared on reset or any state change, counts while waiting
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_r <= '0;
        end else if (enable) begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    assign expired = (TIMEOUT_CYCLES > 0) && (cnt_r == LAST);

endmodule

// File: rtl/five_stage_ctrl_fsm.sv
// Multi-cycle control sequencer for processor_five_stage.
// Define FIVE_STAGE_PERF_CNT_EN to build the cycle/retire performance counters.
module five_stage_ctrl_fsm
    import five_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             branch_taken,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic [2:0]       current_state,
    output logic             imem_req,
    output logic             ir_load,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             rf_re,
    output logic             alu_en,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             rf_we,
    output logic             instr_retire,
    output logic             halted,
    output logic             illegal_op,
    output logic             bus_err,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt
);
    state_t state_r;
    state_t state_next;
    logic   set_illegal;
    logic   set_bus;
    logic   wait_expired;

    five_stage_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_next != state_r),
        .enable ((state_r == ST_FETCH) || (state_r == ST_MEM)),
        .expired(wait_expired)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_next;
        end
    end

    // Next-state and strobe decode; strobes are held low while reset is asserted
    always_comb begin
        state_next   = state_r;
        imem_req     = 1'b0;
        ir_load      = 1'b0;
        pc_inc       = 1'b0;
        pc_load      = 1'b0;
        rf_re        = 1'b0;
        alu_en       = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        rf_we        = 1'b0;
        instr_retire = 1'b0;
        set_illegal  = 1'b0;
        set_bus      = 1'b0;
        if (reset) begin
            state_next = ST_FETCH;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        ir_load    = 1'b1;
                        pc_inc     = 1'b1;
                        state_next = ST_DECODE;
                    end else if (wait_expired) begin
                        state_next = ST_HALT;
                        set_bus    = 1'b1;
                    end else begin
                        state_next = ST_FETCH;
                    end
                end
                ST_DECODE: begin
                    rf_re = 1'b1;
                    if (opcode == OP_HALT) begin
                        state_next   = ST_HALT;
                        instr_retire = 1'b1;
                    end else if (!is_legal_op(opcode)) begin
                        state_next  = ST_HALT;
                        set_illegal = 1'b1;
                    end else begin
                        state_next = ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    alu_en = 1'b1;
                    case (opcode)
                        OP_LD, OP_ST:    state_next = ST_MEM;
                        OP_ALU, OP_ALUI: state_next = ST_WRITE_OUT;
                        OP_BR: begin
                            pc_load      = branch_taken;
                            instr_retire = 1'b1;
                            state_next   = ST_FETCH;
                        end
                        OP_JMP: begin
                            pc_load      = 1'b1;
                            instr_retire = 1'b1;
                            state_next   = ST_FETCH;
                        end
                        default: begin
                            state_next  = ST_HALT;
                            set_illegal = 1'b1;
                        end
                    endcase
                end
                ST_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = (opcode == OP_ST);
                    if (dmem_ack) begin
                        if (opcode == OP_ST) begin
                            instr_retire = 1'b1;
                            state_next   = ST_FETCH;
                        end else begin
                            state_next = ST_WRITE_OUT;
                        end
                    end else if (wait_expired) begin
                        state_next = ST_HALT;
                        set_bus    = 1'b1;
                    end else begin
                        state_next = ST_MEM;
                    end
                end
                ST_WRITE_OUT: begin
                    rf_we        = 1'b1;
                    instr_retire = 1'b1;
                    state_next   = ST_FETCH;
                end
                ST_HALT: begin
                    state_next = ST_HALT;
                end
                default: begin
                    state_next  = ST_HALT;
                    set_illegal = 1'b1;
                end
            endcase
        end
    end

    // Sticky halt cause flags
    always_ff @(posedge clk) begin
        if (reset) begin
            halted     <= 1'b0;
            illegal_op <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            if (state_next == ST_HALT) halted     <= 1'b1;
            if (set_illegal)           illegal_op <= 1'b1;
            if (set_bus)               bus_err    <= 1'b1;
        end
    end

    assign current_state = state_r;

`ifdef FIVE_STAGE_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_r;
    logic [CNT_W-1:0] retire_cnt_r;

    // Performance counters, frozen once halted
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt_r  <= '0;
            retire_cnt_r <= '0;
        end else if (state_r != ST_HALT) begin
            cycle_cnt_r <= cycle_cnt_r + CNT_W'(1);
            if (instr_retire) retire_cnt_r <= retire_cnt_r + CNT_W'(1);
        end
    end

    assign cycle_cnt  = cycle_cnt_r;
    assign retire_cnt = retire_cnt_r;
`else
    assign cycle_cnt  = '0;
    assign retire_cnt = '0;
`endif

endmodule
